// File: rtl/spiral_gen_multi.sv
// spiral_gen_multi: two-stage rotating multi-arm spiral pattern generator with frame-driven rotation and palette cycling
module spiral_gen_multi #(
  parameter int H_CENTER      = 320,
  parameter int V_CENTER      = 240,
  parameter int NUM_ARMS      = 6,
  parameter int ARM_SHIFT     = 4,
  parameter int HOLE_RADIUS   = 20,
  parameter int FRAC_BITS     = 2,
  parameter int BOUNCE_FRAMES = 120,
  parameter int PAL_PERIOD    = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pattern_enable,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       de_in,
  input  logic       next_frame,
  input  logic [2:0] step_size,
  input  logic [1:0] dir_mode,
  output logic [5:0] rgb,
  output logic       de_out
);
  localparam int AW = 6 + FRAC_BITS;
  localparam int BW = BOUNCE_FRAMES > 1 ? $clog2(BOUNCE_FRAMES) : 1;
  localparam int PW = PAL_PERIOD > 1 ? $clog2(PAL_PERIOD) : 1;
  localparam logic [9:0] HC = 10'(H_CENTER);
  localparam logic [9:0] VC = 10'(V_CENTER);
  localparam logic [3:0] NA = 4'(NUM_ARMS);
  localparam logic [10:0] HOLE = 11'(HOLE_RADIUS);
  localparam logic [5:0] PALETTE [8] = '{6'b010001, 6'b100011, 6'b111010, 6'b001110,
                                         6'b011101, 6'b101111, 6'b110000, 6'b000111};
  typedef enum logic {FWD, REV} dir_t;
  dir_t dir_state, dir_next;
  logic [AW-1:0] acc, acc_next, step;
  logic [BW-1:0] bounce_cnt, bounce_next;
  logic [PW-1:0] pal_cnt, pal_cnt_next;
  logic [2:0] pal_off, pal_off_next;
  logic upd, ping, fwd, rev, bounce_end, pal_end;
  logic [9:0] dx, dy;
  logic [10:0] s1_radius;
  logic [2:0] s1_sector;
  logic s1_de;
  logic [5:0] angle, rgb_next;
  logic [6:0] phase;
  logic [2:0] arm, cidx;
  logic [3:0] sum;
  logic in_arm;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dir_state  <= FWD;
      acc        <= '0;
      bounce_cnt <= '0;
      pal_cnt    <= '0;
      pal_off    <= '0;
    end else begin
      dir_state  <= dir_next;
      acc        <= acc_next;
      bounce_cnt <= bounce_next;
      pal_cnt    <= pal_cnt_next;
      pal_off    <= pal_off_next;
    end
  always_comb begin
    upd          = pattern_enable && next_frame;
    ping         = dir_mode == 2'b10;
    step         = AW'(step_size);
    fwd          = dir_mode == 2'b00 || (ping && dir_state == FWD);
    rev          = dir_mode == 2'b01 || (ping && dir_state == REV);
    bounce_end   = bounce_cnt == BW'(BOUNCE_FRAMES - 1);
    pal_end      = pal_cnt == PW'(PAL_PERIOD - 1);
    acc_next     = !upd ? acc : fwd ? acc + step : rev ? acc - step : acc;
    dir_next     = !upd ? dir_state : !ping ? FWD : !bounce_end ? dir_state : dir_state == FWD ? REV : FWD;
    bounce_next  = !upd ? bounce_cnt : (!ping || bounce_end) ? '0 : bounce_cnt + BW'(1);
    pal_cnt_next = (!upd || PAL_PERIOD == 0) ? pal_cnt : pal_end ? '0 : pal_cnt + PW'(1);
    pal_off_next = (!upd || PAL_PERIOD == 0 || !pal_end) ? pal_off :
                   pal_off == 3'(NUM_ARMS - 1) ? '0 : pal_off + 3'd1;
  end
  always_comb begin
    dx = x >= HC ? x - HC : HC - x;
    dy = y >= VC ? y - VC : VC - y;
  end
  // Angle is sector*8 plus the integer part of the rotation accumulator; pitch subtracts the scaled radius
  always_comb begin
    angle    = {s1_sector, 3'b000} + acc[AW-1 -: 6];
    phase    = {1'b0, angle} - 7'(s1_radius >> ARM_SHIFT);
    arm      = phase[6:4];
    in_arm   = !phase[3] && {1'b0, arm} < NA && s1_radius > HOLE;
    sum      = {1'b0, arm} + {1'b0, pal_off};
    cidx     = 3'(sum >= NA ? sum - NA : sum);
    rgb_next = (in_arm && s1_de) ? PALETTE[cidx] : 6'd0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_radius <= '0;
      s1_sector <= '0;
      s1_de     <= 1'b0;
      rgb       <= '0;
      de_out    <= 1'b0;
    end else begin
      s1_radius <= {1'b0, dx} + {1'b0, dy};
      s1_sector <= {x >= HC, y >= VC, dx > dy};
      s1_de     <= de_in;
      rgb       <= rgb_next;
      de_out    <= s1_de;
    end
endmodule

// File: tb/tb_spiral_gen_multi.sv
// tb_spiral_gen_multi: directed checks of rotation, ping-pong, palette cycling, hole and latency
module tb_spiral_gen_multi;
  logic clk = 1'b0, rst = 1'b1, pe = 1'b1, de_in = 1'b0, nf_a = 1'b0, nf_b = 1'b0;
  logic [9:0] x = '0, y = '0;
  logic [2:0] step = '0;
  logic [1:0] dm = '0;
  logic [5:0] rgb_a, rgb_b;
  logic de_a, de_b;
  int passes = 0, total = 0;
  int seq [6] = '{1, 2, 3, 2, 1, 0};

  always #5 clk = ~clk;

  spiral_gen_multi #(.BOUNCE_FRAMES(3)) u_a (
    .clk(clk), .rst(rst), .pattern_enable(pe), .x(x), .y(y), .de_in(de_in),
    .next_frame(nf_a), .step_size(step), .dir_mode(dm), .rgb(rgb_a), .de_out(de_a));

  spiral_gen_multi #(.NUM_ARMS(3), .PAL_PERIOD(2)) u_b (
    .clk(clk), .rst(rst), .pattern_enable(pe), .x(x), .y(y), .de_in(de_in),
    .next_frame(nf_b), .step_size(step), .dir_mode(dm), .rgb(rgb_b), .de_out(de_b));

  task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %b, need %b", tag, obs, exp);
  endtask

  task automatic pix(input logic [9:0] px, input logic [9:0] py);
    x = px; y = py; de_in = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
  endtask

  task automatic probe_a(input string tag, input logic [9:0] px, input logic [9:0] py, input logic [5:0] exp);
    pix(px, py);
    chk(tag, rgb_a, exp);
  endtask

  // Sector-7 pixels whose phase sits at the first and last slot of arm 3 for offset o (0..7)
  task automatic off_a(input string tag, input int o);
    probe_a({tag, "_lo"}, 10'(456 + 16 * o), 10'd240, 6'b001110);
    probe_a({tag, "_hi"}, 10'(344 + 16 * o), 10'd240, 6'b001110);
  endtask

  task automatic upd_a(input int n);
    repeat (n) begin
      nf_a = 1'b1; @(posedge clk); @(negedge clk); nf_a = 1'b0;
    end
  endtask

  task automatic upd_b(input int n);
    repeat (n) begin
      nf_b = 1'b1; @(posedge clk); @(negedge clk); nf_b = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    x = 10'd400; y = 10'd240; de_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rgb", rgb_a, 6'd0);
    chk("rst_de", {5'd0, de_a}, 6'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("lat1_de", {5'd0, de_a}, 6'd0);
    @(negedge clk);
    chk("lat2_de", {5'd0, de_a}, 6'd1);
    chk("lat2_rgb", rgb_a, 6'b001110);
    probe_a("hole_r0", 10'd320, 10'd240, 6'd0);
    probe_a("hole_r20d", 10'd330, 10'd250, 6'd0);
    probe_a("hole_r20", 10'd340, 10'd240, 6'd0);
    probe_a("ring_r21", 10'd341, 10'd240, 6'b001110);
    de_in = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("de_low_rgb", rgb_a, 6'd0);
    chk("de_low_de", {5'd0, de_a}, 6'd0);
    off_a("o0", 0);
    pe = 1'b0; step = 3'd4; dm = 2'b00;
    upd_a(4);
    pe = 1'b1;
    off_a("gated", 0);
    step = 3'd1;
    upd_a(3);
    off_a("frac3", 0);
    upd_a(1);
    off_a("frac4", 1);
    do_reset();
    step = 3'd7;
    upd_a(10);
    probe_a("o17_lo", 10'd472, 10'd239, 6'b001110);
    probe_a("o17_hi", 10'd360, 10'd239, 6'b001110);
    do_reset();
    dm = 2'b01; step = 3'd4;
    upd_a(1);
    probe_a("o63_lo", 10'd196, 10'd116, 6'b001110);
    probe_a("o63_hi", 10'd252, 10'd172, 6'b001110);
    do_reset();
    dm = 2'b10;
    for (int i = 0; i < 6; i++) begin
      upd_a(1);
      off_a($sformatf("pp%0d", i), seq[i]);
    end
    upd_a(2);
    off_a("pp_mid", 2);
    dm = 2'b00;
    upd_a(1);
    off_a("fwd_force", 3);
    dm = 2'b10;
    upd_a(2);
    off_a("pp_restart", 5);
    upd_a(1);
    off_a("pp_top", 6);
    upd_a(1);
    off_a("pp_turn", 5);
    dm = 2'b00;
    rst = 1'b1; nf_a = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0; nf_a = 1'b0;
    off_a("rst_wins", 0);
    pix(10'd341, 10'd240);
    chk("pre_rst", rgb_a, 6'b001110);
    rst = 1'b1;
    #1;
    chk("mid_rst_rgb", rgb_a, 6'd0);
    chk("mid_rst_de", {5'd0, de_a}, 6'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst1_de", {5'd0, de_a}, 6'd0);
    @(negedge clk);
    chk("post_rst2_de", {5'd0, de_a}, 6'd1);
    dm = 2'b11; step = 3'd4;
    pix(10'd648, 10'd240);
    chk("pal0", rgb_b, 6'b111010);
    pix(10'd456, 10'd240);
    chk("arm3_b", rgb_b, 6'd0);
    chk("arm3_a", rgb_a, 6'b001110);
    upd_b(2);
    pix(10'd648, 10'd240);
    chk("pal2", rgb_b, 6'b010001);
    upd_b(1);
    pix(10'd648, 10'd240);
    chk("pal3", rgb_b, 6'b010001);
    upd_b(1);
    pix(10'd648, 10'd240);
    chk("pal4", rgb_b, 6'b100011);
    upd_b(2);
    pix(10'd648, 10'd240);
    chk("pal6_wrap", rgb_b, 6'b111010);
    chk("de_b", {5'd0, de_b}, 6'd1);
    pix(10'd456, 10'd240);
    chk("arm3_b_late", rgb_b, 6'd0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
